// File: rtl/usart_echo_fifo.sv
// UART echo: 2-flop synchronised RX deserialiser -> DEPTH-entry FIFO -> TX serialiser.
// Optional parity bit enabled by defining USART_ECHO_PARITY_EN (PARITY_ODD selects odd/even).
module usart_echo_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                     comm_clock,
  input  logic                     reset_n,
  input  logic [11:0]              clocks_per_bit,
  input  logic                     echo_enable,
  input  logic                     clear_errors,
  input  logic                     rx_pin,
  output logic                     tx_pin,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     framing_error,
  output logic                     parity_error
);

  localparam int   AW   = $clog2(DEPTH);
  localparam int   IW   = $clog2(DATA_BITS);
  localparam logic PODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef USART_ECHO_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef USART_ECHO_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  logic [11:0] cpb;
  assign cpb = (clocks_per_bit < 12'd2) ? 12'd2 : clocks_per_bit;

  logic rx_meta, rxs, rxs_d;
  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  rx_state_t            rx_state, rx_state_n;
  logic [11:0]          rx_cnt, rx_cnt_n, rx_cpb, rx_cpb_n;
  logic [IW-1:0]        rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic                 rx_push, push_n, fe_set;
`ifdef USART_ECHO_PARITY_EN
  logic                 rx_par_bad, rx_par_bad_n, pe_set;
`endif

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_cpb_n   = rx_cpb;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    push_n     = 1'b0;
    fe_set     = 1'b0;
`ifdef USART_ECHO_PARITY_EN
    rx_par_bad_n = rx_par_bad;
    pe_set       = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: if (rxs_d && !rxs) begin
        rx_state_n = RX_START;
        rx_cnt_n   = (cpb >> 1) - 12'd1;
        rx_cpb_n   = cpb;
`ifdef USART_ECHO_PARITY_EN
        rx_par_bad_n = 1'b0;
`endif
      end
      RX_START: if (rx_cnt == '0) begin
        if (rxs) rx_state_n = RX_IDLE;
        else begin
          rx_state_n = RX_DATA;
          rx_cnt_n   = rx_cpb - 12'd1;
          rx_idx_n   = '0;
        end
      end else rx_cnt_n = rx_cnt - 12'd1;
      RX_DATA: if (rx_cnt == '0) begin
        rx_shift_n = {rxs, rx_shift[DATA_BITS-1:1]};
        rx_cnt_n   = rx_cpb - 12'd1;
        if (rx_idx == IW'(DATA_BITS - 1)) begin
`ifdef USART_ECHO_PARITY_EN
          rx_state_n = RX_PARITY;
`else
          rx_state_n = RX_STOP;
`endif
        end else rx_idx_n = rx_idx + 1'b1;
      end else rx_cnt_n = rx_cnt - 12'd1;
`ifdef USART_ECHO_PARITY_EN
      RX_PARITY: if (rx_cnt == '0) begin
        if ((^rx_shift ^ rxs) != PODD) begin
          rx_par_bad_n = 1'b1;
          pe_set       = 1'b1;
        end
        rx_cnt_n   = rx_cpb - 12'd1;
        rx_state_n = RX_STOP;
      end else rx_cnt_n = rx_cnt - 12'd1;
`endif
      RX_STOP: if (rx_cnt == '0) begin
        if (rxs) begin
`ifdef USART_ECHO_PARITY_EN
          push_n = !rx_par_bad;
`else
          push_n = 1'b1;
`endif
          rx_state_n = RX_IDLE;
        end else begin
          fe_set     = 1'b1;
          rx_state_n = RX_WAIT_HIGH;
        end
      end else rx_cnt_n = rx_cnt - 12'd1;
      RX_WAIT_HIGH: if (rxs) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_cpb   <= 12'd2;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
`ifdef USART_ECHO_PARITY_EN
      rx_par_bad <= 1'b0;
`endif
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_cpb   <= rx_cpb_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rx_push  <= push_n;
`ifdef USART_ECHO_PARITY_EN
      rx_par_bad <= rx_par_bad_n;
`endif
    end
  end

  // FIFO: rx_shift holds the frame unchanged during the push cycle, so it is the write data.
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW:0]          wptr, rptr;
  logic                 full, empty, pop, do_push, ov_set;
  logic [DATA_BITS-1:0] head;

  assign fifo_level = wptr - rptr;
  assign full       = (fifo_level == (AW+1)'(DEPTH));
  assign empty      = (fifo_level == '0);
  assign do_push    = rx_push && (!full || pop);
  assign ov_set     = rx_push && full && !pop;
  assign head       = mem[rptr[AW-1:0]];

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge comm_clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= rx_shift;
  end

  tx_state_t            tx_state, tx_state_n;
  logic [11:0]          tx_cnt, tx_cnt_n, tx_cpb, tx_cpb_n;
  logic [IW-1:0]        tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_data, tx_data_n;
  logic                 tx_pin_n, can_pop;

  assign can_pop = !empty && echo_enable;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_cpb_n   = tx_cpb;
    tx_idx_n   = tx_idx;
    tx_data_n  = tx_data;
    pop        = 1'b0;
    case (tx_state)
      TX_IDLE: if (can_pop) begin
        pop        = 1'b1;
        tx_data_n  = head;
        tx_cpb_n   = cpb;
        tx_cnt_n   = cpb - 12'd1;
        tx_state_n = TX_START;
      end
      TX_START: if (tx_cnt == '0) begin
        tx_state_n = TX_DATA;
        tx_cnt_n   = tx_cpb - 12'd1;
        tx_idx_n   = '0;
      end else tx_cnt_n = tx_cnt - 12'd1;
      TX_DATA: if (tx_cnt == '0) begin
        tx_cnt_n = tx_cpb - 12'd1;
        if (tx_idx == IW'(DATA_BITS - 1)) begin
`ifdef USART_ECHO_PARITY_EN
          tx_state_n = TX_PARITY;
`else
          tx_state_n = TX_STOP;
`endif
        end else tx_idx_n = tx_idx + 1'b1;
      end else tx_cnt_n = tx_cnt - 12'd1;
`ifdef USART_ECHO_PARITY_EN
      TX_PARITY: if (tx_cnt == '0) begin
        tx_cnt_n   = tx_cpb - 12'd1;
        tx_state_n = TX_STOP;
      end else tx_cnt_n = tx_cnt - 12'd1;
`endif
      TX_STOP: if (tx_cnt == '0) begin
        if (can_pop) begin
          pop        = 1'b1;
          tx_data_n  = head;
          tx_cpb_n   = cpb;
          tx_cnt_n   = cpb - 12'd1;
          tx_state_n = TX_START;
        end else tx_state_n = TX_IDLE;
      end else tx_cnt_n = tx_cnt - 12'd1;
      default: tx_state_n = TX_IDLE;
    endcase

    // Output is registered from the next state so tx_pin is glitch-free.
    case (tx_state_n)
      TX_START:  tx_pin_n = 1'b0;
      TX_DATA:   tx_pin_n = tx_data_n[tx_idx_n];
`ifdef USART_ECHO_PARITY_EN
      TX_PARITY: tx_pin_n = ^tx_data_n ^ PODD;
`endif
      default:   tx_pin_n = 1'b1;
    endcase
  end

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_cpb   <= 12'd2;
      tx_idx   <= '0;
      tx_data  <= '0;
      tx_pin   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_cpb   <= tx_cpb_n;
      tx_idx   <= tx_idx_n;
      tx_data  <= tx_data_n;
      tx_pin   <= tx_pin_n;
    end
  end

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      overflow      <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      overflow      <= ov_set | (overflow & ~clear_errors);
      framing_error <= fe_set | (framing_error & ~clear_errors);
    end
  end

`ifdef USART_ECHO_PARITY_EN
  always_ff @(posedge comm_clock) begin
    if (!reset_n) parity_error <= 1'b0;
    else          parity_error <= pe_set | (parity_error & ~clear_errors);
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule
